// File: rtl/memory_io_pkg.sv
// Shared definitions for the memory/I-O handshake block: pipeline latencies,
// I/O window address decode and the one-hot select width helper.
package memory_io_pkg;

  localparam int READ_LATENCY  = 2;
  localparam int WRITE_LATENCY = 1;

  // True when addr lies inside the I/O window [base, base + count)
  function automatic logic is_io_addr(input logic [31:0] addr,
                                      input logic [31:0] base,
                                      input logic [31:0] count);
    return (addr >= base) && (addr < (base + count));
  endfunction

  // Port index of an address already known to lie inside the I/O window
  function automatic logic [31:0] io_port_index(input logic [31:0] addr,
                                                input logic [31:0] base);
    return addr - base;
  endfunction

  // Width of a one-hot vector able to select every index of idx_width bits
  function automatic int onehot_width(input int idx_width);
    return int'(32'd1 << idx_width);
  endfunction

endpackage

// File: rtl/RAM_SDP_NEW.sv
// Simple dual-port RAM primitive: one registered write port, one registered
// read port whose output holds while rden is low. Contents are never reset.
// Read-during-write returns old data unless the MLAB style is selected.
module RAM_SDP_NEW #(
  parameter int DATA_WIDTH = 36,
  parameter int ADDR_WIDTH = 10,
  parameter int DEPTH      = 1024,
  parameter     RAMSTYLE   = "M10K",
  parameter     INIT_FILE  = ""
) (
  input  logic                  clock,
  input  logic                  wren,
  input  logic [ADDR_WIDTH-1:0] wraddress,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  rden,
  input  logic [ADDR_WIDTH-1:0] rdaddress,
  output logic [DATA_WIDTH-1:0] q
);

  localparam bit NEW_DATA_RDW = (RAMSTYLE == "MLAB");

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  // Storage write port
  always_ff @(posedge clock) begin
    if (wren) begin
      mem_r[wraddress] <= data;
    end
  end

  // Registered read port, holding its last word while idle
  always_ff @(posedge clock) begin
    if (rden) begin
      if (NEW_DATA_RDW && wren && (wraddress == rdaddress)) begin
        q <= data;
      end else begin
        q <= mem_r[rdaddress];
      end
    end
  end

endmodule

// File: rtl/io_port_decode.sv
// Address decoder: flags I/O window hits, produces the one-hot port select
// and reports whether the address is a RAM word the block may touch.
module io_port_decode
  import memory_io_pkg::*;
#(
  parameter int ADDR_WIDTH         = 10,
  parameter int MEM_DEPTH          = 1024,
  parameter int IO_PORT_COUNT      = 4,
  parameter int IO_PORT_BASE_ADDR  = 1016,
  parameter int IO_PORT_ADDR_WIDTH = 2
) (
  input  logic [ADDR_WIDTH-1:0]    addr_i,
  output logic                     is_io_o,
  output logic [IO_PORT_COUNT-1:0] port_sel_o,
  output logic                     in_range_o
);

  localparam int SEL_W = onehot_width(IO_PORT_ADDR_WIDTH);

  logic [31:0]                   addr_ext_s;
  logic                          is_io_s;
  logic [IO_PORT_ADDR_WIDTH-1:0] index_s;
  logic [SEL_W-1:0]              sel_full_s;

  assign addr_ext_s = 32'(addr_i);
  assign is_io_s    = is_io_addr(addr_ext_s, 32'(IO_PORT_BASE_ADDR), 32'(IO_PORT_COUNT));
  assign index_s    = IO_PORT_ADDR_WIDTH'(io_port_index(addr_ext_s, 32'(IO_PORT_BASE_ADDR)));

  // One-hot port select, all zero outside the I/O window
  always_comb begin
    sel_full_s = '0;
    if (is_io_s) begin
      sel_full_s = SEL_W'(1'b1) << index_s;
    end else begin
      sel_full_s = '0;
    end
  end

  // I/O addresses shadow RAM; address 0 and words past the RAM are not RAM
  assign is_io_o    = is_io_s;
  assign port_sel_o = sel_full_s[IO_PORT_COUNT-1:0];
  assign in_range_o = !is_io_s && (addr_ext_s != 32'd0) && (addr_ext_s < 32'(MEM_DEPTH));

endmodule

// File: rtl/memory_io_handshake.sv
// Memory plus memory-mapped I/O ports behind one read and one write channel.
// Reads return two cycles after the address; writes land one cycle after
// being registered. I/O ports use ready/strobe handshakes, and a RAM read
// colliding with the pending RAM write is served from a bypass register.
module memory_io_handshake
  import memory_io_pkg::*;
#(
  parameter int WORD_WIDTH         = 36,
  parameter int ADDR_WIDTH         = 10,
  parameter int MEM_DEPTH          = 1024,
  parameter     MEM_RAMSTYLE       = "M10K",
  parameter     MEM_INIT_FILE      = "",
  parameter int IO_PORT_COUNT      = 4,
  parameter int IO_PORT_BASE_ADDR  = 1016,
  parameter int IO_PORT_ADDR_WIDTH = 2,
  parameter int WRITE_FORWARDING   = 1
) (
  input  logic                                clock,
  input  logic                                reset_n,
  input  logic                                read_enable,
  input  logic [ADDR_WIDTH-1:0]               read_addr,
  output logic [WORD_WIDTH-1:0]               read_data,
  output logic                                read_ok,
  input  logic [WORD_WIDTH*IO_PORT_COUNT-1:0] io_read_data,
  input  logic [IO_PORT_COUNT-1:0]            io_read_ready,
  output logic [IO_PORT_COUNT-1:0]            io_rden,
  input  logic                                write_enable,
  input  logic [ADDR_WIDTH-1:0]               write_addr,
  input  logic [WORD_WIDTH-1:0]               write_data,
  output logic                                write_ok,
  input  logic [IO_PORT_COUNT-1:0]            io_write_ready,
  output logic [IO_PORT_COUNT-1:0]            io_wren,
  output logic [WORD_WIDTH*IO_PORT_COUNT-1:0] io_write_data
);

  localparam int IO_BUS_W = WORD_WIDTH * IO_PORT_COUNT;

  // Address decode results
  logic                     rd_is_io_s, rd_in_range_s, wr_is_io_s, wr_in_range_s;
  logic [IO_PORT_COUNT-1:0] rd_sel_s, wr_sel_s;

  // Read path
  logic                     ram_rden_s, fwd_hit_s;
  logic [IO_PORT_COUNT-1:0] rd_strobe_s;
  logic [WORD_WIDTH-1:0]    rd_word_s, ram_q_s;
  logic                     rd_valid_q, rd_ram_q, rd_io_q, rd_io_hit_q, fwd_hit_q;
  logic [WORD_WIDTH-1:0]    rd_io_word_q, fwd_data_q;
  logic [IO_PORT_COUNT-1:0] io_rden_q;
  logic [WORD_WIDTH-1:0]    read_data_d, read_data_q;
  logic                     read_ok_d, read_ok_q;

  // Write path
  logic [IO_PORT_COUNT-1:0] wr_accept_s;
  logic                     wr_ram_d, write_ok_d;
  logic                     wr_ram_q, write_ok_q;
  logic [ADDR_WIDTH-1:0]    wr_addr_q;
  logic [WORD_WIDTH-1:0]    wr_data_q;
  logic [IO_PORT_COUNT-1:0] wr_io_sel_q, io_wren_q;
  logic [IO_BUS_W-1:0]      io_write_data_d, io_write_data_q;

  io_port_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .MEM_DEPTH(MEM_DEPTH), .IO_PORT_COUNT(IO_PORT_COUNT),
    .IO_PORT_BASE_ADDR(IO_PORT_BASE_ADDR), .IO_PORT_ADDR_WIDTH(IO_PORT_ADDR_WIDTH)
  ) u_rd_decode (
    .addr_i(read_addr), .is_io_o(rd_is_io_s), .port_sel_o(rd_sel_s), .in_range_o(rd_in_range_s)
  );

  io_port_decode #(
    .ADDR_WIDTH(ADDR_WIDTH), .MEM_DEPTH(MEM_DEPTH), .IO_PORT_COUNT(IO_PORT_COUNT),
    .IO_PORT_BASE_ADDR(IO_PORT_BASE_ADDR), .IO_PORT_ADDR_WIDTH(IO_PORT_ADDR_WIDTH)
  ) u_wr_decode (
    .addr_i(write_addr), .is_io_o(wr_is_io_s), .port_sel_o(wr_sel_s), .in_range_o(wr_in_range_s)
  );

  RAM_SDP_NEW #(
    .DATA_WIDTH(WORD_WIDTH), .ADDR_WIDTH(ADDR_WIDTH), .DEPTH(MEM_DEPTH),
    .RAMSTYLE(MEM_RAMSTYLE), .INIT_FILE(MEM_INIT_FILE)
  ) u_ram (
    .clock(clock), .wren(wr_ram_q), .wraddress(wr_addr_q), .data(wr_data_q),
    .rden(ram_rden_s), .rdaddress(read_addr), .q(ram_q_s)
  );

  // The RAM is read at the same edge that commits the pending write, so a
  // matching address must take the pending word instead of the stale one.
  assign ram_rden_s = read_enable && rd_in_range_s;
  assign fwd_hit_s  = (WRITE_FORWARDING != 0) && ram_rden_s && wr_ram_q && (read_addr == wr_addr_q);

  // I/O read handshake: strobe only a ready port and pick its word
  always_comb begin
    rd_strobe_s = '0;
    rd_word_s   = '0;
    if (read_enable && rd_is_io_s) begin
      rd_strobe_s = rd_sel_s & io_read_ready;
    end else begin
      rd_strobe_s = '0;
    end
    for (int p = 0; p < IO_PORT_COUNT; p++) begin
      if (rd_strobe_s[p]) begin
        rd_word_s = rd_word_s | io_read_data[p*WORD_WIDTH +: WORD_WIDTH];
      end else begin
        rd_word_s = rd_word_s;
      end
    end
  end

  // Read stage 1: sample the I/O word, raise the read strobe, note bypass
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_valid_q   <= 1'b0;
      rd_ram_q     <= 1'b0;
      rd_io_q      <= 1'b0;
      rd_io_hit_q  <= 1'b0;
      rd_io_word_q <= '0;
      fwd_hit_q    <= 1'b0;
      fwd_data_q   <= '0;
      io_rden_q    <= '0;
    end else begin
      rd_valid_q   <= read_enable;
      rd_ram_q     <= ram_rden_s;
      rd_io_q      <= read_enable && rd_is_io_s;
      rd_io_hit_q  <= |rd_strobe_s;
      rd_io_word_q <= rd_word_s;
      fwd_hit_q    <= fwd_hit_s;
      fwd_data_q   <= wr_data_q;
      io_rden_q    <= rd_strobe_s;
    end
  end

  // Read result select: RAM (or bypass), sampled I/O word, or zero
  always_comb begin
    read_data_d = '0;
    if (rd_ram_q) begin
      if (fwd_hit_q) begin
        read_data_d = fwd_data_q;
      end else begin
        read_data_d = ram_q_s;
      end
    end else if (rd_io_hit_q) begin
      read_data_d = rd_io_word_q;
    end else begin
      read_data_d = '0;
    end
    read_ok_d = rd_valid_q && !(rd_io_q && !rd_io_hit_q);
  end

  // Read stage 2: registered read outputs
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      read_data_q <= '0;
      read_ok_q   <= 1'b0;
    end else begin
      read_data_q <= read_data_d;
      read_ok_q   <= read_ok_d;
    end
  end

  // Write accept: I/O writes need the port ready, every other write is taken
  always_comb begin
    wr_accept_s = '0;
    if (write_enable && wr_is_io_s) begin
      wr_accept_s = wr_sel_s & io_write_ready;
    end else begin
      wr_accept_s = '0;
    end
    wr_ram_d   = write_enable && wr_in_range_s;
    write_ok_d = write_enable && (!wr_is_io_s || (|wr_accept_s));
  end

  // Write stage 1: hold the pending write until it is committed
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ram_q    <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      wr_io_sel_q <= '0;
      write_ok_q  <= 1'b0;
    end else begin
      wr_ram_q    <= wr_ram_d;
      wr_addr_q   <= write_addr;
      wr_data_q   <= write_data;
      wr_io_sel_q <= wr_accept_s;
      write_ok_q  <= write_ok_d;
    end
  end

  // Replace only the word of the port receiving an accepted write
  always_comb begin
    io_write_data_d = io_write_data_q;
    for (int p = 0; p < IO_PORT_COUNT; p++) begin
      if (wr_io_sel_q[p]) begin
        io_write_data_d[p*WORD_WIDTH +: WORD_WIDTH] = wr_data_q;
      end else begin
        io_write_data_d[p*WORD_WIDTH +: WORD_WIDTH] = io_write_data_q[p*WORD_WIDTH +: WORD_WIDTH];
      end
    end
  end

  // Write stage 2: port words and the single-cycle write strobe
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      io_write_data_q <= '0;
      io_wren_q       <= '0;
    end else begin
      io_write_data_q <= io_write_data_d;
      io_wren_q       <= wr_io_sel_q;
    end
  end

  assign read_data     = read_data_q;
  assign read_ok       = read_ok_q;
  assign io_rden       = io_rden_q;
  assign write_ok      = write_ok_q;
  assign io_wren       = io_wren_q;
  assign io_write_data = io_write_data_q;

endmodule

// File: doc/memory_io_handshake.md
MEMORY_IO_HANDSHAKE -- requirements
Module: memory_io_handshake

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- WORD_WIDTH, 36, data word width.
- ADDR_WIDTH, 10, address width.
- MEM_DEPTH, 1024, RAM words.
- MEM_RAMSTYLE, "M10K", RAM synthesis attribute.
- MEM_INIT_FILE, "", RAM init file.
- IO_PORT_COUNT, 4, number of I/O ports.
- IO_PORT_BASE_ADDR, 1016, address of port 0.
- IO_PORT_ADDR_WIDTH, 2, port index width.
- WRITE_FORWARDING, 1, enables read-during-write forwarding.

REQ-002 Ports SHALL be (name, direction, width, meaning):
- clock, in, 1, sole clock.
- reset_n, in, 1, asynchronous active-low reset.
- read_enable, in, 1, read request.
- read_addr, in, ADDR_WIDTH, read address.
- read_data, out, WORD_WIDTH, read result.
- read_ok, out, 1, read completed (not an unready I/O port).
- io_read_data, in, WORD_WIDTH*IO_PORT_COUNT, port read words.
- io_read_ready, in, IO_PORT_COUNT, port has data.
- io_rden, out, IO_PORT_COUNT, port read strobe.
- write_enable, in, 1, write request.
- write_addr, in, ADDR_WIDTH, write address.
- write_data, in, WORD_WIDTH, write word.
- write_ok, out, 1, write accepted.
- io_write_ready, in, IO_PORT_COUNT, port can accept.
- io_wren, out, IO_PORT_COUNT, port write strobe.
- io_write_data, out, WORD_WIDTH*IO_PORT_COUNT, per-port held write words.

REQ-003 One clock; reset is asynchronous and active-low.

Function
REQ-004 The block SHALL decode I/O addresses internally: port p = address IO_PORT_BASE_ADDR+p, for p < IO_PORT_COUNT. I/O addresses shadow RAM.
REQ-005 Read latency SHALL be 2 cycles: address in cycle N, read_data/read_ok valid in cycle N+2, fully pipelined at one read per cycle.
REQ-006 RAM read enable SHALL be deasserted for address 0, I/O addresses, addresses >= MEM_DEPTH, or read_enable=0.
REQ-007 Address 0, addresses >= MEM_DEPTH (non-I/O), and read_enable=0 SHALL yield read_data=0 with read_ok=1 (read_ok=0 when read_enable=0).
REQ-008 I/O read to port p in cycle N with io_read_ready[p]=1:
- io_read_data[p] SHALL be sampled at the end of cycle N.
- io_rden[p] SHALL pulse high for cycle N+1 only.
- read_data SHALL equal the sampled word, with read_ok=1, in cycle N+2.
REQ-009 I/O read to port p with io_read_ready[p]=0: no io_rden pulse; read_data=0 and read_ok=0 in cycle N+2.
REQ-010 Write pipeline: write in cycle N is registered at the end of cycle N, and the RAM is written at the end of cycle N+1. Writes to address 0, addresses >= MEM_DEPTH, or with write_enable=0 SHALL be discarded.
REQ-011 I/O write to port p in cycle N with io_write_ready[p]=1:
- write_ok SHALL be 1 in cycle N+1.
- io_write_data word p SHALL hold the new value from cycle N+2 until the next accepted write to p.
- io_wren[p] SHALL be high for cycle N+2 only.
- Other port words SHALL be unchanged.
REQ-012 I/O write with io_write_ready[p]=0: write_ok=0 in cycle N+1, no strobe, no data change. RAM and other writes: write_ok=1.
REQ-013 With WRITE_FORWARDING=1, a RAM read whose address matches the stage-2 pending write in the same cycle SHALL return the new data. With WRITE_FORWARDING=0, the result SHALL be undefined and left to MEM_RAMSTYLE.
REQ-014 A simultaneous read and write to the same I/O port SHALL be handled independently; the read handshake SHALL NOT affect the write handshake.
REQ-015 At most one bit of io_rden and one bit of io_wren SHALL be high per cycle.

Reset
REQ-016 While reset_n=0, all outputs SHALL be zero: read_data, read_ok, write_ok, io_rden, io_wren, and io_write_data.
REQ-017 Reset SHALL clear all pipeline registers, so in-flight reads/writes are dropped. RAM contents SHALL NOT be reset.
REQ-018 The first operation after reset_n rises SHALL follow REQ-005 and REQ-010 timing exactly.

Structure
REQ-019 A shared package memory_io_pkg SHALL hold:
- the port-address decode function;
- the read/write latency constants (2, 1);
- the one-hot width helper.
REQ-020 A sub-module io_port_decode SHALL be used for address decode: address -> is_io, one-hot port select, in_range. It SHALL be instantiated once for reads and once for writes.
REQ-021 RAM SHALL be the existing simple-dual-port RAM primitive RAM_SDP_NEW. Forwarding SHALL be a bypass mux outside it.

Verification
REQ-022 Write 0x123456789 to address 5 in cycle 0, then read address 5 in cycle 1 -> read_data=0x123456789 in cycle 3 via forwarding (WRITE_FORWARDING=1).
REQ-023 Write 0xFFFFFFFFF to address 0, then read address 0 -> read_data=0, read_ok=1, RAM unchanged.
REQ-024 Read 1017 with io_read_ready=4'b0010 and port-1 data 0xABC:
- io_rden=4'b0010 for exactly one cycle;
- read_data=0xABC, read_ok=1, two cycles after the address.
REQ-025 Write 0x55 to 1018 with io_write_ready[2]=0:
- write_ok=0, io_wren stays 0, port-2 word unchanged;
- retry with ready=1 -> io_wren=4'b0100 for one cycle, port-2 word=0x55.
REQ-026 Issue RAM writes every cycle, assert reset_n=0 mid-stream for one cycle:
- all outputs go to 0 immediately;
- the pending stage-2 write is not committed;
- subsequent writes and reads complete with nominal latency.
